// File: rtl/pps_pkg.sv
// Shared PPS definitions: phase-detector FSM states and the default timing constants
// used by both the phase detector and the local divider.
package pps_pkg;

  localparam int PPS_PULSE        = 10_000_000;
  localparam int PPS_WINDOW       = 10_000;
  localparam int PPS_RESET_THRESH = 100;
  localparam int PPS_LOCK_THRESH  = 10;
  localparam int PPS_LOCK_COUNT   = 4;
  localparam int PPS_LOST_TIMEOUT = 12_000_000;

  typedef enum logic [1:0] {
    IDLE,
    GPS_FIRST,
    LOC_FIRST
  } pps_state_t;

  // Magnitude on 17 bits so that -32768 does not wrap back to itself.
  function automatic logic [16:0] abs17(input logic signed [15:0] v);
    logic signed [16:0] w;
    w = {v[15], v};
    return w[16] ? 17'(-w) : 17'(w);
  endfunction

endpackage

// File: rtl/pps_edge_sync.sv
// Two-flop synchroniser followed by a rising-edge detector; used for both PPS inputs
// so that the GPS and local edge strobes see identical latency.
module pps_edge_sync (
  input  logic CLK_SYS,
  input  logic CLK_RST,
  input  logic i_pulse,
  output logic o_rise
);

  logic [1:0] r_sync;
  logic       r_prev;

  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_pulse};
      r_prev <= r_sync[1];
    end
  end

  assign o_rise = r_sync[1] & ~r_prev;

endmodule

// File: rtl/pps_phase_det.sv
// Measures local-minus-GPS PPS phase in CLK_SYS cycles, orders divider resyncs on large
// errors, and tracks lock and GPS loss.
module pps_phase_det
  import pps_pkg::*;
#(
  parameter int PULSE        = PPS_PULSE,
  parameter int WINDOW       = PPS_WINDOW,
  parameter int RESET_THRESH = PPS_RESET_THRESH,
  parameter int LOCK_THRESH  = PPS_LOCK_THRESH,
  parameter int LOCK_COUNT   = PPS_LOCK_COUNT,
  parameter int LOST_TIMEOUT = PPS_LOST_TIMEOUT
) (
  input  logic               CLK_SYS,
  input  logic               CLK_RST,
  input  logic               _1PPS_GPS,
  input  logic               _1PPS_Local,
  output logic signed [15:0] PHASE_ERR,
  output logic               PHASE_VALID,
  output logic               DIV_RESET,
  output logic               LOCKED,
  output logic               GPS_LOST
);

  // A window wider than one PPS period could never close, so clamp it below PULSE.
  localparam int          CNT_MAX = (WINDOW < PULSE) ? WINDOW : PULSE - 1;
  localparam logic [15:0] CNT_LIM = 16'(CNT_MAX);
  localparam logic [23:0] TO_LIM  = 24'(LOST_TIMEOUT);
  localparam logic [3:0]  RUN_LIM = 4'(LOCK_COUNT);
  localparam logic [16:0] RST_TH  = 17'(RESET_THRESH);
  localparam logic [16:0] LCK_TH  = 17'(LOCK_THRESH);

  logic [1:0] w_pins;
  logic [1:0] w_edges;
  logic       w_gps_edge;
  logic       w_loc_edge;

  assign w_pins = {_1PPS_Local, _1PPS_GPS};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      pps_edge_sync u_sync (
        .CLK_SYS (CLK_SYS),
        .CLK_RST (CLK_RST),
        .i_pulse (w_pins[gi]),
        .o_rise  (w_edges[gi])
      );
    end
  endgenerate

  assign w_gps_edge = w_edges[0];
  assign w_loc_edge = w_edges[1];

  pps_state_t         r_state, w_state_next;
  logic [15:0]        r_cnt, w_cnt_next;
  logic               w_res_valid;
  logic               w_overrange;
  logic signed [15:0] w_err;
  logic [16:0]        w_err_abs;
  logic [23:0]        r_to_cnt, w_to_cnt_next;
  logic               w_lost_next;
  logic [3:0]         r_run, w_run_next;
  logic               w_div_next;

  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_res_valid  = 1'b0;
    w_overrange  = 1'b0;
    w_err        = '0;
    if (GPS_LOST) begin
      w_state_next = IDLE;
      w_cnt_next   = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_gps_edge && w_loc_edge) begin
            w_res_valid = 1'b1;
          end else if (w_gps_edge) begin
            w_state_next = GPS_FIRST;
            w_cnt_next   = 16'd1;
          end else if (w_loc_edge) begin
            w_state_next = LOC_FIRST;
            w_cnt_next   = 16'd1;
          end
        end
        GPS_FIRST: begin
          if (w_loc_edge) begin
            w_res_valid  = 1'b1;
            w_err        = $signed(r_cnt);
            w_state_next = IDLE;
            w_cnt_next   = '0;
          end else if (w_gps_edge) begin
            w_cnt_next = 16'd1;
          end else if (r_cnt >= CNT_LIM) begin
            w_res_valid  = 1'b1;
            w_overrange  = 1'b1;
            w_err        = $signed(CNT_LIM);
            w_state_next = IDLE;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 16'd1;
          end
        end
        LOC_FIRST: begin
          if (w_gps_edge) begin
            w_res_valid  = 1'b1;
            w_err        = -$signed(r_cnt);
            w_state_next = IDLE;
            w_cnt_next   = '0;
          end else if (w_loc_edge) begin
            w_cnt_next = 16'd1;
          end else if (r_cnt >= CNT_LIM) begin
            w_res_valid  = 1'b1;
            w_overrange  = 1'b1;
            w_err        = -$signed(CNT_LIM);
            w_state_next = IDLE;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 16'd1;
          end
        end
        default: begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  assign w_err_abs = abs17(w_err);

  always_comb begin
    w_to_cnt_next = r_to_cnt;
    if (w_gps_edge) begin
      w_to_cnt_next = '0;
    end else if (r_to_cnt != TO_LIM) begin
      w_to_cnt_next = r_to_cnt + 24'd1;
    end
  end

  assign w_lost_next = (w_to_cnt_next == TO_LIM);
  assign w_div_next  = w_res_valid && !w_lost_next && (w_overrange || (w_err_abs > RST_TH));

  // Any disqualifying event drops the run counter in the same cycle the result appears.
  always_comb begin
    w_run_next = r_run;
    if (w_lost_next) begin
      w_run_next = '0;
    end else if (w_res_valid) begin
      if (w_div_next || (w_err_abs > LCK_TH)) begin
        w_run_next = '0;
      end else if (r_run != RUN_LIM) begin
        w_run_next = r_run + 4'd1;
      end
    end
  end

  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) begin
      r_to_cnt    <= '0;
      r_run       <= '0;
      PHASE_ERR   <= '0;
      PHASE_VALID <= 1'b0;
      DIV_RESET   <= 1'b0;
      LOCKED      <= 1'b0;
      GPS_LOST    <= 1'b0;
    end else begin
      r_to_cnt    <= w_to_cnt_next;
      r_run       <= w_run_next;
      PHASE_VALID <= w_res_valid;
      DIV_RESET   <= w_div_next;
      LOCKED      <= (w_run_next == RUN_LIM);
      GPS_LOST    <= w_lost_next;
      if (w_res_valid) begin
        PHASE_ERR <= w_err;
      end
    end
  end

endmodule

// File: tb/tb_pps_phase_det.sv
// Directed and randomized PPS edge pairs checked against a timing/arithmetic model of
// the phase detector, plus GPS-loss and mid-measurement reset scenarios.
module tb_pps_phase_det;

  localparam int P_PULSE = 1000;
  localparam int P_WIN   = 300;
  localparam int P_RT    = 100;
  localparam int P_LT    = 10;
  localparam int P_LC    = 4;
  localparam int P_LOST  = 2000;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic gps_pin = 1'b0;
  logic loc_pin = 1'b0;
  logic signed [15:0] phase_err;
  logic phase_valid, div_reset, locked, gps_lost;

  always #50 clk = ~clk;

  pps_phase_det #(
    .PULSE        (P_PULSE),
    .WINDOW       (P_WIN),
    .RESET_THRESH (P_RT),
    .LOCK_THRESH  (P_LT),
    .LOCK_COUNT   (P_LC),
    .LOST_TIMEOUT (P_LOST)
  ) dut (
    .CLK_SYS     (clk),
    .CLK_RST     (rst_n),
    ._1PPS_GPS   (gps_pin),
    ._1PPS_Local (loc_pin),
    .PHASE_ERR   (phase_err),
    .PHASE_VALID (phase_valid),
    .DIV_RESET   (div_reset),
    .LOCKED      (locked),
    .GPS_LOST    (gps_lost)
  );

  typedef struct {
    int   c;
    int   e;
    logic d;
    logic l;
  } res_t;

  int   cyc = 0;
  res_t res_q[$];
  int   div_total = 0;
  int   div_stray = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   run_model = 0;
  int   last_gps_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (phase_valid) res_q.push_back('{c: cyc, e: int'(phase_err), d: div_reset, l: locked});
      if (div_reset) div_total <= div_total + 1;
      if (div_reset && !phase_valid) div_stray <= div_stray + 1;
    end
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic bit pulse_on(input int t, input int at);
    return (at >= 0) && (t >= at) && (t < at + 3);
  endfunction

  // Pin times are cycles relative to the first drive; -1 means that pulse is absent.
  task automatic run_meas(input string tag, input int g1, input int g2, input int l1);
    int e, t_res, g_last, t_end, k0, d0;
    bit ovr, dv, lk;
    ovr    = 0;
    g_last = (g2 >= 0) ? g2 : g1;
    if (l1 < 0) begin
      e = P_WIN; t_res = g_last + P_WIN; ovr = 1;
    end else if (g1 < 0) begin
      e = -P_WIN; t_res = l1 + P_WIN; ovr = 1;
    end else if (g1 <= l1) begin
      e = l1 - g_last; t_res = l1;
    end else begin
      e = l1 - g1; t_res = g1;
    end
    dv = ovr || (iabs(e) > P_RT);
    if (dv || iabs(e) > P_LT) run_model = 0;
    else if (run_model < P_LC) run_model++;
    lk = (run_model == P_LC);
    d0 = div_total;
    res_q.delete();
    t_end = t_res + 8;
    @(negedge clk);
    k0 = cyc;
    for (int t = 0; t <= t_end; t++) begin
      if (t > 0) @(negedge clk);
      gps_pin = pulse_on(t, g1) || pulse_on(t, g2);
      loc_pin = pulse_on(t, l1);
    end
    chk($sformatf("%s.count", tag), res_q.size(), 1);
    if (res_q.size() > 0) begin
      chk($sformatf("%s.cycle", tag), res_q[0].c, k0 + t_res + 3);
      chk($sformatf("%s.err", tag), res_q[0].e, e);
      chk($sformatf("%s.div", tag), res_q[0].d, dv);
      chk($sformatf("%s.locked", tag), res_q[0].l, lk);
    end
    chk($sformatf("%s.div_pulses", tag), div_total - d0, dv ? 1 : 0);
    if (g1 >= 0) last_gps_cyc = k0 + g_last;
    $display("meas %s: err=%0d div=%0b locked=%0b (model err=%0d div=%0b locked=%0b)",
             tag, phase_err, div_reset, locked, e, dv, lk);
  endtask

  initial begin
    int pred, k, mode, d, d0;
    bit prev_loc_only;

    repeat (3) @(negedge clk);
    chk("rst.err", phase_err, 0);
    chk("rst.valid", phase_valid, 0);
    chk("rst.div", div_reset, 0);
    chk("rst.locked", locked, 0);
    chk("rst.lost", gps_lost, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_meas("lead37", 0, -1, 37);
    run_meas("lag150", 150, -1, 0);
    run_meas("eq100", 0, -1, 100);
    run_meas("eqm100", 100, -1, 0);
    run_meas("gt101", 0, -1, 101);
    run_meas("gps_only", 0, -1, -1);
    run_meas("loc_only", -1, -1, 0);
    run_meas("repeat_gps", 0, 40, 70);
    for (int i = 0; i < 4; i++) run_meas($sformatf("lock%0d", i), 0, -1, 0);
    run_meas("err10", 0, -1, 10);
    run_meas("err11", 0, -1, 11);

    prev_loc_only = 1'b1;
    for (int i = 0; i < 24; i++) begin
      mode = int'($urandom_range(0, 9));
      if (mode == 0) begin
        run_meas($sformatf("rnd%0d", i), 0, -1, -1);
        prev_loc_only = 1'b0;
      end else if (mode == 1 && !prev_loc_only) begin
        run_meas($sformatf("rnd%0d", i), -1, -1, 0);
        prev_loc_only = 1'b1;
      end else begin
        if (mode < 6) d = int'($urandom_range(0, 24)) - 12;
        else d = int'($urandom_range(0, 500)) - 250;
        if (d >= 0) run_meas($sformatf("rnd%0d", i), 0, -1, d);
        else run_meas($sformatf("rnd%0d", i), -d, -1, 0);
        prev_loc_only = 1'b0;
      end
    end

    for (int i = 0; i < 4; i++) run_meas($sformatf("relock%0d", i), 0, -1, 0);
    pred = last_gps_cyc + 3 + P_LOST;
    d0 = div_total;
    res_q.delete();
    while (cyc < pred - 1) @(negedge clk);
    chk("lost.before", gps_lost, 0);
    chk("lost.locked_before", locked, 1);
    @(negedge clk);
    chk("lost.set", gps_lost, 1);
    chk("lost.locked_cleared", locked, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); loc_pin = 1'b1;
      repeat (3) @(negedge clk);
      loc_pin = 1'b0;
      repeat (P_WIN + 50) @(negedge clk);
    end
    chk("lost.no_results", res_q.size(), 0);
    chk("lost.no_div", div_total - d0, 0);
    chk("lost.still", gps_lost, 1);
    @(negedge clk); gps_pin = 1'b1; k = cyc;
    repeat (2) @(negedge clk);
    chk("lost.hold", gps_lost, 1);
    @(negedge clk); gps_pin = 1'b0;
    chk("lost.clear", gps_lost, 0);
    $display("lost: cleared at cycle %0d after GPS drive at %0d", cyc, k);
    run_model = 0;
    repeat (20) @(negedge clk);
    run_meas("post_lost", 0, -1, 25);

    res_q.delete();
    @(negedge clk); gps_pin = 1'b1;
    repeat (3) @(negedge clk);
    gps_pin = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.err", phase_err, 0);
    chk("midrst.valid", phase_valid, 0);
    chk("midrst.div", div_reset, 0);
    chk("midrst.locked", locked, 0);
    chk("midrst.lost", gps_lost, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_model = 0;
    repeat (P_WIN + 50) @(negedge clk);
    chk("midrst.no_result", res_q.size(), 0);
    run_meas("post_rst", 40, -1, 0);

    chk("stray_div", div_stray, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
